// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write engine.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_REG,
        ST_ACK2,
        ST_DATA,
        ST_ACK3,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_RISE   = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_FALL   = 2'd3;

    localparam logic        RW_WRITE        = 1'b0;
    localparam int unsigned BYTES_PER_WRITE = 3;

    // Bus levels for a given state/phase, returned as {scl, sda_oe}.
    function automatic logic [1:0] bus_drive(state_t st, logic [1:0] ph, logic bit_v);
        logic scl_hi;
        scl_hi = (ph == PH_RISE) || (ph == PH_SAMPLE);
        case (st)
            ST_START: begin
                if (ph == PH_SETUP)     bus_drive = 2'b10;
                else if (ph == PH_FALL) bus_drive = 2'b01;
                else                    bus_drive = 2'b11;
            end
            ST_ADDR, ST_REG, ST_DATA: bus_drive = {scl_hi, ~bit_v};
            ST_ACK1, ST_ACK2, ST_ACK3: bus_drive = {scl_hi, 1'b0};
            ST_STOP: begin
                if (ph == PH_SETUP)     bus_drive = 2'b01;
                else if (ph == PH_RISE) bus_drive = 2'b11;
                else                    bus_drive = 2'b10;
            end
            default: bus_drive = 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/i2c_write_master_bit_timer.sv
// Quarter-bit phase counter and bit-within-byte counter for the I2C write engine.
module i2c_bit_timer
    import i2c_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       bit_en_i,
    output logic [1:0] phase_o,
    output logic [1:0] phase_next_o,
    output logic       last_phase_o,
    output logic       last_bit_o
);

    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;

    assign last_phase_o = (phase_q == PH_FALL);
    assign last_bit_o   = (bit_q == 3'd7);
    assign phase_o      = phase_q;
    assign phase_next_o = phase_d;

    always_comb begin
        phase_d = load_i ? PH_SETUP : phase_q + 2'd1;
        bit_d   = bit_q;
        if (load_i)
            bit_d = '0;
        else if (bit_en_i && last_phase_o)
            bit_d = bit_q + 3'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single register write over I2C: START, {addr,W}, reg, data with ACK slots, STOP.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter bit ACK_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic       nack_q, nack_d;
    logic       ack_err_q, ack_err_d;
    logic       scl_q, sda_oe_q, busy_q, done_q;

    logic [1:0] phase, phase_next, drive_d;
    logic       last_phase, last_bit, load, bit_en;

    assign load   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bit_en = (state_q == ST_ADDR) || (state_q == ST_REG) || (state_q == ST_DATA);

    i2c_bit_timer u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load),
        .bit_en_i     (bit_en),
        .phase_o      (phase),
        .phase_next_o (phase_next),
        .last_phase_o (last_phase),
        .last_bit_o   (last_bit)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = {dev_addr, RW_WRITE};
                    reg_d     = reg_addr;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: if (last_phase) state_d = ST_ADDR;
            ST_ADDR, ST_REG, ST_DATA: begin
                if (last_phase) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    if (last_bit) begin
                        case (state_q)
                            ST_ADDR: state_d = ST_ACK1;
                            ST_REG:  state_d = ST_ACK2;
                            default: state_d = ST_ACK3;
                        endcase
                    end
                end
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                if (phase == PH_SAMPLE) nack_d = sda_in;
                if (last_phase) begin
                    if (ACK_CHECK && nack_q) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else begin
                        case (state_q)
                            ST_ACK1: begin shreg_d = reg_q;   state_d = ST_REG;  end
                            ST_ACK2: begin shreg_d = wdata_q; state_d = ST_DATA; end
                            default: state_d = ST_STOP;
                        endcase
                    end
                end
            end
            ST_STOP: if (last_phase) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state/phase so they line up with state_q.
    assign drive_d = bus_drive(state_d, phase_next, shreg_d[7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            scl_q     <= drive_d[1];
            sda_oe_q  <= drive_d[0];
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master: one ACK_CHECK=1 and one ACK_CHECK=0 instance on shared stimulus.
module tb_i2c_write_master;
    import i2c_pkg::*;

    localparam int MAXC = 125;
    localparam int BUS_CYCLES = 4 + int'(BYTES_PER_WRITE) * 36 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wdata = '0;
    logic       slave_ack = 1'b0;

    logic busy_a, done_a, ack_err_a, scl_a, sda_oe_a, sda_in_a;
    logic busy_b, done_b, ack_err_b, scl_b, sda_oe_b, sda_in_b;

    assign sda_in_a = ~sda_oe_a & ~slave_ack;
    assign sda_in_b = ~sda_oe_b & ~slave_ack;

    i2c_write_master #(.ACK_CHECK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .wdata(wdata), .busy(busy_a), .done(done_a), .ack_err(ack_err_a), .scl(scl_a),
        .sda_oe(sda_oe_a), .sda_in(sda_in_a)
    );

    i2c_write_master #(.ACK_CHECK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .wdata(wdata), .busy(busy_b), .done(done_b), .ack_err(ack_err_b), .scl(scl_b),
        .sda_oe(sda_oe_b), .sda_in(sda_in_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rscl  [0:1][0:MAXC];
    logic rline [0:1][0:MAXC];
    logic roe   [0:1][0:MAXC];
    logic rbusy [0:1][0:MAXC];
    int   done_at [0:1];
    int   ndone   [0:1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_ack(input int k);
        for (int b = 0; b < 3; b++)
            if (k >= 37 + 36 * b && k <= 40 + 36 * b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] get_byte(input int u, input int base);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], rline[u][base + 4 * i + 1]};
        return v;
    endfunction

    function automatic bit bit_timing_ok(input int u, input int base);
        for (int i = 0; i < 8; i++) begin
            int c = base + 4 * i;
            if (rscl[u][c] !== 1'b0 || rscl[u][c+1] !== 1'b1 || rscl[u][c+2] !== 1'b1 || rscl[u][c+3] !== 1'b0)
                return 1'b0;
            if (rline[u][c+1] !== rline[u][c] || rline[u][c+2] !== rline[u][c] || rline[u][c+3] !== rline[u][c])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    // Cycle k is the k-th clk period after the accepting edge T0.
    task automatic run_xfer(input logic [6:0] da, input logic [7:0] ra, input logic [7:0] wd,
                            input bit ack_on, input bit extra, input int rst_cyc);
        for (int u = 0; u < 2; u++) begin
            done_at[u] = -1;
            ndone[u]   = 0;
        end
        @(posedge clk); #1;
        dev_addr = da; reg_addr = ra; wdata = wd; start = 1'b1; slave_ack = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= MAXC; k++) begin
            start     = extra && (k == 10 || k == 117);
            slave_ack = ack_on && in_ack(k);
            if (k == rst_cyc) begin
                rst = 1'b1;
                #1;
                check_eq("rst_mid_scl", 32'(scl_a), 32'd1);
                check_eq("rst_mid_oe", 32'(sda_oe_a), 32'd0);
                check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
                start = 1'b0; slave_ack = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            #1;
            rscl[0][k] = scl_a; rline[0][k] = sda_in_a; roe[0][k] = sda_oe_a; rbusy[0][k] = busy_a;
            rscl[1][k] = scl_b; rline[1][k] = sda_in_b; roe[1][k] = sda_oe_b; rbusy[1][k] = busy_b;
            if (done_a) begin ndone[0]++; if (done_at[0] < 0) done_at[0] = k; end
            if (done_b) begin ndone[1]++; if (done_at[1] < 0) done_at[1] = k; end
            @(posedge clk); #1;
        end
        start = 1'b0; slave_ack = 1'b0;
    endtask

    task automatic verify_full(input int u, input string nm, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b [0:2];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
        check_eq({nm, "_start_p0"}, {30'd0, rscl[u][1], rline[u][1]}, 32'b11);
        check_eq({nm, "_start_p1"}, {30'd0, rscl[u][2], rline[u][2]}, 32'b10);
        check_eq({nm, "_start_p3"}, {30'd0, rscl[u][4], rline[u][4]}, 32'b00);
        for (int b = 0; b < 3; b++) begin
            check_eq($sformatf("%s_byte%0d", nm, b), 32'(get_byte(u, 5 + 36 * b)), 32'(exp_b[b]));
            check_eq($sformatf("%s_timing%0d", nm, b), 32'(bit_timing_ok(u, 5 + 36 * b)), 32'd1);
            check_eq($sformatf("%s_ackrel%0d", nm, b), 32'(roe[u][39 + 36 * b]), 32'd0);
        end
        check_eq({nm, "_stop_p0"}, {30'd0, rscl[u][113], rline[u][113]}, 32'b00);
        check_eq({nm, "_stop_p1"}, {30'd0, rscl[u][114], rline[u][114]}, 32'b10);
        check_eq({nm, "_stop_p2"}, {30'd0, rscl[u][115], rline[u][115]}, 32'b11);
        check_eq({nm, "_stop_p3"}, {30'd0, rscl[u][116], rline[u][116]}, 32'b11);
        check_eq({nm, "_done_at"}, 32'(done_at[u]), 32'(BUS_CYCLES + 1));
        check_eq({nm, "_ndone"}, 32'(ndone[u]), 32'd1);
        check_eq({nm, "_busy117"}, 32'(rbusy[u][117]), 32'd1);
        check_eq({nm, "_busy118"}, 32'(rbusy[u][118]), 32'd0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_scl", 32'(scl_a), 32'd1);
        check_eq("rst_oe", 32'(sda_oe_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_ackerr", 32'(ack_err_a), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("idle_scl", 32'(scl_a), 32'd1);
            check_eq("idle_oe", 32'(sda_oe_a), 32'd0);
            check_eq("idle_busy", 32'(busy_a), 32'd0);
            check_eq("idle_done", 32'(done_a), 32'd0);
        end

        // Full write, all bytes ACKed.
        run_xfer(7'h50, 8'h1A, 8'hC3, 1'b1, 1'b0, 0);
        verify_full(0, "full_a", 8'hA0, 8'h1A, 8'hC3);
        verify_full(1, "full_b", 8'hA0, 8'h1A, 8'hC3);
        check_eq("full_ackline", 32'(rline[0][75]), 32'd0);
        check_eq("full_ackerr", 32'(ack_err_a), 32'd0);

        // NACK on the address byte.
        run_xfer(7'h50, 8'h1A, 8'hC3, 1'b0, 1'b0, 0);
        check_eq("nack_byte0", 32'(get_byte(0, 5)), 32'hA0);
        check_eq("nack_ackrel", 32'(roe[0][39]), 32'd0);
        check_eq("nack_stop_p0", {30'd0, rscl[0][41], rline[0][41]}, 32'b00);
        check_eq("nack_stop_p1", {30'd0, rscl[0][42], rline[0][42]}, 32'b10);
        check_eq("nack_stop_p2", {30'd0, rscl[0][43], rline[0][43]}, 32'b11);
        check_eq("nack_stop_p3", {30'd0, rscl[0][44], rline[0][44]}, 32'b11);
        check_eq("nack_done_at", 32'(done_at[0]), 32'd45);
        check_eq("nack_ndone", 32'(ndone[0]), 32'd1);
        check_eq("nack_busy46", 32'(rbusy[0][46]), 32'd0);
        check_eq("nack_ackerr", 32'(ack_err_a), 32'd1);
        verify_full(1, "nochk_b", 8'hA0, 8'h1A, 8'hC3);
        check_eq("nochk_ackerr", 32'(ack_err_b), 32'd0);

        // A following ACKed transfer clears the sticky flag.
        run_xfer(7'h2C, 8'h05, 8'h7E, 1'b1, 1'b0, 0);
        verify_full(0, "clr_a", 8'h58, 8'h05, 8'h7E);
        check_eq("clr_ackerr", 32'(ack_err_a), 32'd0);

        // start re-pulsed at cycles 10 and 117 must be ignored.
        run_xfer(7'h50, 8'h1A, 8'hC3, 1'b1, 1'b1, 0);
        verify_full(0, "restart_a", 8'hA0, 8'h1A, 8'hC3);
        for (int k = 118; k <= MAXC; k++)
            check_eq($sformatf("restart_idle%0d", k), 32'(rbusy[0][k]), 32'd0);

        // Reset mid-transfer, then a clean transfer.
        run_xfer(7'h50, 8'h1A, 8'hC3, 1'b1, 1'b0, 60);
        check_eq("postrst_ackerr", 32'(ack_err_a), 32'd0);
        run_xfer(7'h33, 8'hF0, 8'h0F, 1'b1, 1'b0, 0);
        verify_full(0, "postrst_a", 8'h66, 8'hF0, 8'h0F);
        check_eq("postrst_ackerr2", 32'(ack_err_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
